// File: rtl/pid_duty_pkg.sv
// Shared constants, steering mode type and saturation helpers for the pitch-loop PID
// and its neighbouring PWM / sensor blocks.
package pid_duty_pkg;

    localparam int ERR_W_DEF   = 10;
    localparam int D_W_DEF     = 7;
    localparam int DUTY_W_DEF  = 12;
    localparam int P_COEFF_DEF = 5;
    localparam int D_COEFF_DEF = 9;
    localparam int I_SHIFT_DEF = 4;
    localparam int INTEG_W_DEF = 18;
    localparam int D_DECIM_DEF = 4;

    typedef enum logic [1:0] {
        STEER_NONE,
        STEER_ADD,
        STEER_SUB
    } steer_mode_e;

    // Clamp x into the range of a w-bit two's complement number.
    function automatic int sat_s(input int x, input int w);
        int hi;
        int lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Magnitude of a w-bit signed value, the most negative code folded onto the max magnitude.
    function automatic int abs_clamp(input int x, input int w);
        int hi;
        int m;
        hi = (1 <<< (w - 1)) - 1;
        m  = (x < 0) ? -x : x;
        return (m > hi) ? hi : m;
    endfunction

endpackage

// File: rtl/duty_mag.sv
// One motor side: apply steering offset, saturate, and register direction plus duty magnitude.
module duty_mag
    import pid_duty_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld_i,
    input  logic signed [DUTY_W-1:0] pid_i,
    input  logic signed [DUTY_W-1:0] steer_i,
    input  steer_mode_e              mode_i,
    output logic        [DUTY_W-2:0] duty_o,
    output logic                     rev_o
);

    logic [DUTY_W-2:0] duty_q, duty_d;
    logic              rev_q, rev_d;

    always_comb begin : mag_comb
        int v;
        v = int'(pid_i);
        case (mode_i)
            STEER_ADD: v = v + int'(steer_i);
            STEER_SUB: v = v - int'(steer_i);
            default:   v = v;
        endcase
        v      = sat_s(v, DUTY_W);
        duty_d = duty_q;
        rev_d  = rev_q;
        if (vld_i) begin
            rev_d  = (v < 0);
            duty_d = (DUTY_W-1)'(abs_clamp(v, DUTY_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            rev_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            rev_q  <= rev_d;
        end
    end

    assign duty_o = duty_q;
    assign rev_o  = rev_q;

endmodule

// File: rtl/pid_duty_pipe.sv
// Three-stage pitch-loop PID producing per-motor duty magnitude and direction.
// Define PID_DUTY_STEER_EN to apply the steering offset (+left / -right).
module pid_duty_pipe
    import pid_duty_pkg::*;
#(
    parameter int ERR_W   = ERR_W_DEF,
    parameter int D_W     = D_W_DEF,
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int P_COEFF = P_COEFF_DEF,
    parameter int D_COEFF = D_COEFF_DEF,
    parameter int I_SHIFT = I_SHIFT_DEF,
    parameter int INTEG_W = INTEG_W_DEF,
    parameter int D_DECIM = D_DECIM_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld,
    input  logic signed [15:0]       ptch,
    input  logic                     clr_I,
    input  logic signed [DUTY_W-1:0] steer,
    output logic                     duty_vld,
    output logic        [DUTY_W-2:0] lft_duty,
    output logic        [DUTY_W-2:0] rgt_duty,
    output logic                     lft_rev,
    output logic                     rgt_rev
);

    localparam int P_W    = ERR_W + $clog2(P_COEFF) + 1;
    localparam int I_W    = INTEG_W - I_SHIFT;
    localparam int DT_W   = D_W + $clog2(D_COEFF) + 1;
    localparam int SUM_W  = ((P_W > I_W) ? ((P_W > DT_W) ? P_W : DT_W)
                                         : ((I_W > DT_W) ? I_W : DT_W)) + 2;
    localparam int FILL_W = $clog2(D_DECIM + 1);

    logic signed [ERR_W-1:0]   err_sat;
    logic                      s1_vld_q, s1_vld_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic signed [ERR_W-1:0]   lag_q, lag_d;
    logic                      warm_q, warm_d;
    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic signed [ERR_W-1:0]   hist_q [D_DECIM];
    logic signed [ERR_W-1:0]   hist_d [D_DECIM];
    logic        [FILL_W-1:0]  fill_q, fill_d;
    logic                      s2_vld_q, s2_vld_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic                      duty_vld_q, duty_vld_d;
    logic signed [DUTY_W-1:0]  pid_sat;
    steer_mode_e               lft_mode, rgt_mode;

    // S1: the lag sample and warm flag are taken before the history/fill update,
    // so the derivative spans exactly D_DECIM samples.
    always_comb begin : s1_comb
        int base;
        err_sat  = ERR_W'(sat_s(int'(ptch), ERR_W));
        s1_vld_d = vld;
        err_d    = err_q;
        lag_d    = lag_q;
        warm_d   = warm_q;
        integ_d  = integ_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        base     = 0;
        if (vld) begin
            err_d     = err_sat;
            lag_d     = hist_q[D_DECIM-1];
            warm_d    = (fill_q == FILL_W'(D_DECIM));
            base      = clr_I ? 0 : int'(integ_q);
            integ_d   = INTEG_W'(sat_s(base + int'(err_sat), INTEG_W));
            hist_d[0] = err_sat;
            for (int unsigned i = 1; i < D_DECIM; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            if (!warm_d) fill_d = fill_q + 1'b1;
        end else if (clr_I) begin
            integ_d = '0;
        end
    end

    always_comb begin : s2_comb
        int p_t;
        int i_t;
        int dd_t;
        int d_t;
        s2_vld_d = s1_vld_q;
        p_t      = int'(err_q) * P_COEFF;
        i_t      = int'(integ_q) >>> I_SHIFT;
        dd_t     = sat_s(int'(err_q) - int'(lag_q), D_W);
        d_t      = warm_q ? dd_t * D_COEFF : 0;
        sum_d    = SUM_W'(p_t + i_t + d_t);
    end

    always_comb begin : s3_comb
        duty_vld_d = s2_vld_q;
        pid_sat    = DUTY_W'(sat_s(int'(sum_q), DUTY_W));
`ifdef PID_DUTY_STEER_EN
        lft_mode   = STEER_ADD;
        rgt_mode   = STEER_SUB;
`else
        lft_mode   = STEER_NONE;
        rgt_mode   = STEER_NONE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            err_q      <= '0;
            lag_q      <= '0;
            warm_q     <= 1'b0;
            integ_q    <= '0;
            fill_q     <= '0;
            s2_vld_q   <= 1'b0;
            sum_q      <= '0;
            duty_vld_q <= 1'b0;
            for (int unsigned i = 0; i < D_DECIM; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            s1_vld_q   <= s1_vld_d;
            err_q      <= err_d;
            lag_q      <= lag_d;
            warm_q     <= warm_d;
            integ_q    <= integ_d;
            fill_q     <= fill_d;
            s2_vld_q   <= s2_vld_d;
            sum_q      <= sum_d;
            duty_vld_q <= duty_vld_d;
            hist_q     <= hist_d;
        end
    end

    duty_mag #(.DUTY_W(DUTY_W)) u_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (s2_vld_q),
        .pid_i  (pid_sat),
        .steer_i(steer),
        .mode_i (lft_mode),
        .duty_o (lft_duty),
        .rev_o  (lft_rev)
    );

    duty_mag #(.DUTY_W(DUTY_W)) u_rgt (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (s2_vld_q),
        .pid_i  (pid_sat),
        .steer_i(steer),
        .mode_i (rgt_mode),
        .duty_o (rgt_duty),
        .rev_o  (rgt_rev)
    );

    assign duty_vld = duty_vld_q;

endmodule

// File: tb/tb_pid_duty_pipe.sv
// Bench for pid_duty_pipe: arithmetic reference model checked every cycle, plus
// hand-computed directed expectations.
module tb_pid_duty_pipe;

    localparam int DUTY_W = 12;

    logic                     clk   = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     vld   = 1'b0;
    logic                     clr_I = 1'b0;
    logic signed [15:0]       ptch  = '0;
    logic signed [DUTY_W-1:0] steer = '0;
    logic                     duty_vld;
    logic        [DUTY_W-2:0] lft_duty, rgt_duty;
    logic                     lft_rev, rgt_rev;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pid_duty_pipe #(
        .ERR_W(10), .D_W(7), .DUTY_W(DUTY_W), .P_COEFF(5), .D_COEFF(9),
        .I_SHIFT(4), .INTEG_W(18), .D_DECIM(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .clr_I(clr_I), .steer(steer),
        .duty_vld(duty_vld), .lft_duty(lft_duty), .rgt_duty(rgt_duty),
        .lft_rev(lft_rev), .rgt_rev(rgt_rev)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int x, input int lo, input int hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int due; int pid; } exp_t;
    exp_t q[$];
    int   m_integ = 0;
    int   m_fill  = 0;
    int   m_hist[$] = '{0, 0, 0, 0};
    int   cyc = 0;
    int   h_ld = 0, h_lr = 0, h_rd = 0, h_rr = 0;

    always @(negedge rst_n) begin
        m_integ = 0;
        m_fill  = 0;
        m_hist  = '{0, 0, 0, 0};
        q.delete();
        h_ld = 0; h_lr = 0; h_rd = 0; h_rr = 0;
    end

    always @(posedge clk) begin
        int   e, lag, p, iv, dd, d, pid, lv, rv;
        bit   warm, ev;
        exp_t x;
        cyc++;
        if (rst_n && vld) begin
            e    = clampi(ptch, -512, 511);
            warm = (m_fill >= 4);
            lag  = m_hist.pop_front();
            m_hist.push_back(e);
            if (m_fill < 4) m_fill++;
            m_integ = clampi((clr_I ? 0 : m_integ) + e, -131072, 131071);
            p   = e * 5;
            iv  = m_integ >>> 4;
            dd  = clampi(e - lag, -64, 63);
            d   = warm ? dd * 9 : 0;
            pid = clampi(p + iv + d, -2048, 2047);
            q.push_back('{cyc + 2, pid});
        end else if (rst_n && clr_I) begin
            m_integ = 0;
        end
        #1;
        ev = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            x  = q.pop_front();
            ev = 1'b1;
`ifdef PID_DUTY_STEER_EN
            lv = clampi(x.pid + steer, -2048, 2047);
            rv = clampi(x.pid - steer, -2048, 2047);
`else
            lv = x.pid;
            rv = x.pid;
`endif
            h_lr = (lv < 0);
            h_ld = (lv < 0) ? clampi(-lv, 0, 2047) : lv;
            h_rr = (rv < 0);
            h_rd = (rv < 0) ? clampi(-rv, 0, 2047) : rv;
        end
        chk("model_duty_vld", duty_vld, ev);
        chk("model_lft_duty", lft_duty, h_ld);
        chk("model_lft_rev",  lft_rev,  h_lr);
        chk("model_rgt_duty", rgt_duty, h_rd);
        chk("model_rgt_rev",  rgt_rev,  h_rr);
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input int p, input bit c);
        @(negedge clk);
        vld   = 1'b1;
        ptch  = 16'(p);
        clr_I = c;
        @(negedge clk);
        vld   = 1'b0;
        clr_I = 1'b0;
    endtask

    task automatic send_clr();
        @(negedge clk);
        clr_I = 1'b1;
        @(negedge clk);
        clr_I = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input int ld, input int lr, input int rd, input int rr);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(posedge clk);
            #1;
            if (duty_vld) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk({name, "_seen"}, got, 1);
        if (got) begin
            chk({name, "_latency"}, lat, 2);
            chk({name, "_lft_duty"}, lft_duty, ld);
            chk({name, "_lft_rev"},  lft_rev,  lr);
            chk({name, "_rgt_duty"}, rgt_duty, rd);
            chk({name, "_rgt_rev"},  rgt_rev,  rr);
        end
    endtask

    initial begin
        int first, cnt;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_duty_vld", duty_vld, 0);
        chk("rst_lft_duty", lft_duty, 0);
        chk("rst_rgt_rev",  rgt_rev,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(16, 1'b0);
        expect_out("first_sample", 81, 0, 81, 0);

        do_reset();
        send(-30000, 1'b0);
        expect_out("sat_neg", 2047, 1, 2047, 1);

        send_clr();
        repeat (4) send(0, 1'b0);
        repeat (4) @(negedge clk);
        send(100, 1'b0);
        expect_out("deriv_100", 1073, 0, 1073, 0);

        send_clr();
        repeat (4) send(0, 1'b0);
        repeat (4) @(negedge clk);
        send(20, 1'b0);
        expect_out("deriv_20", 281, 0, 281, 0);

        // integrator restarts from this sample: I = 160>>>4 = 10, P = 800, D = 63*9
        send(160, 1'b1);
        expect_out("clr_with_vld", 1377, 0, 1377, 0);

        first = -1;
        cnt   = 0;
        fork
            begin
                int vals[5] = '{10, -20, 300, -700, 40};
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    vld   = 1'b1;
                    ptch  = 16'(vals[k]);
                    clr_I = (k == 2);
                end
                @(negedge clk);
                vld   = 1'b0;
                clr_I = 1'b0;
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    @(posedge clk);
                    #1;
                    if (duty_vld) begin
                        if (first < 0) first = c;
                        cnt++;
                    end
                end
            end
        join
        chk("b2b_first_strobe", first, 3);
        chk("b2b_strobe_count", cnt, 5);

        @(negedge clk);
        vld  = 1'b1;
        ptch = 16'(50);
        @(negedge clk);
        ptch = 16'(60);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_duty_vld", duty_vld, 0);
        chk("midrst_lft_duty", lft_duty, 0);
        chk("midrst_rgt_duty", rgt_duty, 0);
        chk("midrst_lft_rev",  lft_rev,  0);
        @(negedge clk);
        vld   = 1'b0;
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (duty_vld) cnt++;
        end
        chk("midrst_no_strobe", cnt, 0);

        steer = 12'sd100;
        send(16, 1'b0);
`ifdef PID_DUTY_STEER_EN
        expect_out("steer", 181, 0, 19, 1);
`else
        expect_out("steer", 81, 0, 81, 0);
`endif
        steer = '0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
